regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file for the NPC core; successor to the single-write, 2-read file.
//  Supports NRD read ports, two write ports with fixed priority and optional write-to-read bypass.
//  A hardware clear sequencer zeroes every entry after reset or on request.
//  Sits between decode (read addresses) and writeback (writes).
// PARAMETERS
//  XLEN    64  data width in bits
//  NREG    32  number of registers; power of 2, >=2
//  AW      5   address width = $clog2(NREG)
//  NRD     2   number of read ports, >=1
//  BYPASS  1   1: a same-cycle write is forwarded to matching reads; 0: reads return stored value
//  ZERO_R0 1   1: r0 reads as 0 and ignores writes; 0: r0 is an ordinary register
// PORTS
//  clk      in   1         clock, all state updates on posedge
//  rst      in   1         synchronous active-high reset
//  clr_req  in   1         pulse: start clear sequence (honoured only when ready=1)
//  ready    out  1         1 = RUN state; writes accepted, reads valid
//  wen0     in   1         write enable, port 0
//  waddr0   in   AW        write address, port 0
//  wdata0   in   XLEN      write data, port 0
//  wen1     in   1         write enable, port 1 (priority over port 0)
//  waddr1   in   AW        write address, port 1
//  wdata1   in   XLEN      write data, port 1
//  raddr    in   NRD*AW    read addresses; port i = raddr[i*AW +: AW]
//  rdata    out  NRD*XLEN  read data; port i = rdata[i*XLEN +: XLEN], combinational
// BEHAVIOUR
//  States: CLEAR, RUN. The counter cnt is AW+1 bits wide.
//  rst=1 on a posedge: state<=CLEAR, cnt<=0. The array is not touched by rst itself; ready=0 next cycle.
//  CLEAR, rst=0: each cycle writes r[cnt]<=0 and sets cnt<=cnt+1.
//    When cnt==NREG-1, the state goes to RUN after that write.
//    Hence ready rises exactly NREG cycles after the first rst=0 posedge.
//  RUN: clr_req=1 -> state<=CLEAR, cnt<=0. Writes presented in that same cycle are still performed.
//  clr_req is ignored in CLEAR. rst has priority over clr_req and over writes.
//  While ready=0:
//    all rdata ports output 0;
//    wen0/wen1 are ignored (dropped, not queued).
//  RUN writes (posedge):
//    wen0 writes r[waddr0]<=wdata0; wen1 writes r[waddr1]<=wdata1.
//    Both enabled with waddr0==waddr1: port 1 value is stored.
//    ZERO_R0=1: writes to address 0 are discarded.
//  Reads (RUN):
//    ZERO_R0=1 and raddr_i==0 -> rdata_i=0.
//    Else, if BYPASS=1 and wen1 && waddr1==raddr_i -> wdata1.
//    Else, if BYPASS=1 and wen0 && waddr0==raddr_i -> wdata0.
//    Else -> r[raddr_i].
//  The bypass honours the ZERO_R0 discard: a write to address 0 is never forwarded.
//  Read latency 0 (combinational). Write visible to a read the next cycle (same cycle if BYPASS=1).
//  No out-of-range addresses exist (NREG=2^AW).
//  rst asserted mid-CLEAR restarts the sequence from cnt=0.
// TESTING
//  1. Reset release: rst=1 for 2 cycles, then 0 -> ready=0 for 32 cycles, ready=1 on cycle 32; every raddr reads 0.
//  2. Basic write/read: write r5=64'hDEAD_BEEF via port 0 -> raddr0=5 reads 64'hDEAD_BEEF the next cycle; raddr1=0 reads 0.
//  3. Dual-write conflict: same cycle wen0 r7=1 and wen1 r7=2 -> r7 reads 2; different addresses r3=3, r4=4 -> both stored.
//  4. Bypass: BYPASS=1, r9=0x11 and write r9=0x22 -> rdata reads 0x22 in the write cycle. BYPASS=0 -> reads 0x11, then 0x22 next cycle.
//  5. r0 guard: wen1 r0=64'hFFFF with raddr0=0 -> rdata0=0 in that cycle and afterwards. ZERO_R0=0 build -> reads 64'hFFFF.
//  6. Clear request: fill r1..r31 with nonzero values, pulse clr_req -> ready=0 for 32 cycles, all regs read 0 after. A write issued during CLEAR is dropped. rst mid-clear restarts the 32-cycle count.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file for the NPC core.
// NRD combinational read ports, two write ports (port 1 wins on a collision),
// optional same-cycle write-to-read bypass, optional hard-wired zero r0, and
// a clear sequencer that zeroes one entry per cycle after reset or on request.
module regfile_mp #(
    parameter int XLEN    = 64,
    parameter int NREG    = 32,
    parameter int AW      = $clog2(NREG),
    parameter int NRD     = 2,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_req,
    output logic                ready,
    input  logic                wen0,
    input  logic [AW-1:0]       waddr0,
    input  logic [XLEN-1:0]     wdata0,
    input  logic                wen1,
    input  logic [AW-1:0]       waddr1,
    input  logic [XLEN-1:0]     wdata1,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata
);

    localparam logic [0:0]  ST_CLEAR = 1'b0;
    localparam logic [0:0]  ST_RUN   = 1'b1;
    localparam logic [AW:0] CNT_LAST = (AW+1)'(NREG - 1);

    logic [0:0]      state_q, state_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [XLEN-1:0] mem_q [NREG];

    logic clr_wr;   // clear sequencer owns the array write port this cycle
    logic we0;      // port 0 write actually lands in the array
    logic we1;      // port 1 write actually lands in the array

    assign ready  = (state_q == ST_RUN);
    assign clr_wr = !rst && (state_q == ST_CLEAR);

    // Writes are only accepted in RUN, never during rst, and never to r0 when it is hard-wired.
    assign we0 = !rst && ready && wen0 && !(ZERO_R0 && (waddr0 == '0));
    assign we1 = !rst && ready && wen1 && !(ZERO_R0 && (waddr1 == '0));

    // Next-state logic: walk the clear counter, leave for RUN after the last entry, re-enter on clr_req.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches are inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                state_d = ST_RUN;
            end
        end else if (clr_req) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
        end
    end

    // Control state register; rst restarts the clear sequence from entry 0.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Register array: the clear sequencer, else port 0 then port 1 so port 1 wins on equal addresses.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch; the clear sequencer zeroes it so it maps onto plain RAM.
        if (clr_wr) begin
            mem_q[cnt_q[AW-1:0]] <= '0;
        end else begin
            if (we0) begin
                mem_q[waddr0] <= wdata0;
            end
            if (we1) begin
                mem_q[waddr1] <= wdata1;
            end
        end
    end

    // Read ports: zero while not ready or for r0, then bypass (port 1 first), then stored value.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NRD; i++) begin
            if (ready && !(ZERO_R0 && (raddr[i*AW +: AW] == '0))) begin
                if (BYPASS && we1 && (waddr1 == raddr[i*AW +: AW])) begin
                    rdata[i*XLEN +: XLEN] = wdata1;
                end else if (BYPASS && we0 && (waddr0 == raddr[i*AW +: AW])) begin
                    rdata[i*XLEN +: XLEN] = wdata0;
                end else begin
                    rdata[i*XLEN +: XLEN] = mem_q[raddr[i*AW +: AW]];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default build plus a no-bypass build and a
// writable-r0 build, all driven by the same stimulus.
module tb_regfile_mp;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, clr_req;
    logic                wen0, wen1;
    logic [AW-1:0]       waddr0, waddr1;
    logic [XLEN-1:0]     wdata0, wdata1;
    logic [NRD*AW-1:0]   raddr;
    logic                ready, ready_nb, ready_nz;
    logic [NRD*XLEN-1:0] rdata, rdata_nb, rdata_nz;

    int n_vec  = 0;
    int n_miss = 0;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata)
    );

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1'b0), .ZERO_R0(1'b1)) dut_nb (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_nb),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_nb)
    );

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_nz),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_nz)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_writes();
        wen0 = 1'b0; wen1 = 1'b0;
        waddr0 = '0; waddr1 = '0;
        wdata0 = '0; wdata1 = '0;
    endtask

    task automatic set_raddr(input int a0, input int a1);
        raddr = {AW'(a1), AW'(a0)};
    endtask

    // OR of every entry seen through both ports of all three builds.
    task automatic read_all(output logic [XLEN-1:0] acc);
        acc = '0;
        for (int a = 0; a < NREG; a++) begin
            set_raddr(a, NREG - 1 - a);
            #1;
            acc = acc | rdata[63:0] | rdata[127:64] | rdata_nb[63:0] | rdata_nb[127:64]
                      | rdata_nz[63:0] | rdata_nz[127:64];
            tick();
        end
    endtask

    // Cycles until ready rises, with a budget; the optional callback cycle drives a stray write and clr_req.
    task automatic wait_ready(input int stray_at, output int n);
        n = 0;
        while (!ready && n < 100) begin
            idle_writes();
            clr_req = 1'b0;
            if (n == 5 && stray_at >= 0) clr_req = 1'b1;
            if (n == stray_at) begin
                wen0 = 1'b1; waddr0 = 5'd2; wdata0 = 64'h5555;
            end
            tick();
            n++;
        end
        idle_writes();
        clr_req = 1'b0;
    endtask

    logic [XLEN-1:0] acc;
    int n;

    initial begin
        rst = 1'b1; clr_req = 1'b0;
        idle_writes();
        set_raddr(3, 4);

        // 1. Reset release
        tick(); tick();
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_rdata0", rdata[63:0], 64'd0);
        rst = 1'b0;
        #1;
        check("clear_rdata1", rdata[127:64], 64'd0);
        wait_ready(-1, n);
        check("reset_len", 64'(n), 64'd32);
        check("reset_ready_nb", {63'd0, ready_nb}, 64'd1);
        check("reset_ready_nz", {63'd0, ready_nz}, 64'd1);
        read_all(acc);
        check("reset_all_zero", acc, 64'd0);

        // 2. Basic write/read
        wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 64'hDEAD_BEEF;
        set_raddr(5, 0);
        tick();
        idle_writes();
        #1;
        check("basic_r5", rdata[63:0], 64'hDEAD_BEEF);
        check("basic_r0", rdata[127:64], 64'd0);
        check("basic_r5_nb", rdata_nb[63:0], 64'hDEAD_BEEF);

        // 3. Dual-write conflict and distinct addresses
        wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 64'd1;
        wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 64'd2;
        set_raddr(7, 7);
        #1;
        check("conflict_bypass", rdata[63:0], 64'd2);
        tick();
        idle_writes();
        #1;
        check("conflict_r7", rdata_nb[63:0], 64'd2);
        wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 64'd3;
        wen1 = 1'b1; waddr1 = 5'd4; wdata1 = 64'd4;
        tick();
        idle_writes();
        set_raddr(3, 4);
        #1;
        check("dual_r3", rdata[63:0], 64'd3);
        check("dual_r4", rdata[127:64], 64'd4);

        // 4. Bypass versus registered read
        wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 64'h11;
        tick();
        wdata0 = 64'h22;
        set_raddr(9, 9);
        #1;
        check("bypass_on", rdata[63:0], 64'h22);
        check("bypass_off", rdata_nb[63:0], 64'h11);
        tick();
        idle_writes();
        #1;
        check("bypass_off_next", rdata_nb[63:0], 64'h22);
        wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 64'h33;
        wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 64'h44;
        #1;
        check("bypass_prio", rdata[127:64], 64'h44);
        tick();
        idle_writes();

        // 5. r0 guard
        wen1 = 1'b1; waddr1 = 5'd0; wdata1 = 64'hFFFF;
        set_raddr(0, 0);
        #1;
        check("r0_same_cycle", rdata[63:0], 64'd0);
        check("r0_nz_bypass", rdata_nz[63:0], 64'hFFFF);
        tick();
        idle_writes();
        #1;
        check("r0_after", rdata[63:0], 64'd0);
        check("r0_nz_after", rdata_nz[127:64], 64'hFFFF);

        // 6. Clear request: fill r1..r31, then clear
        for (int i = 1; i < NREG; i += 2) begin
            idle_writes();
            wen0 = 1'b1; waddr0 = AW'(i); wdata0 = 64'h1000_0000_0000_0000 | 64'(i);
            if (i + 1 < NREG) begin
                wen1 = 1'b1; waddr1 = AW'(i + 1); wdata1 = 64'h1000_0000_0000_0000 | 64'(i + 1);
            end
            tick();
        end
        idle_writes();
        set_raddr(1, 31);
        #1;
        check("fill_r1", rdata[63:0], 64'h1000_0000_0000_0001);
        check("fill_r31", rdata[127:64], 64'h1000_0000_0000_001F);
        clr_req = 1'b1;
        wen0 = 1'b1; waddr0 = 5'd10; wdata0 = 64'hABC;
        tick();
        clr_req = 1'b0;
        idle_writes();
        check("clr_ready", {63'd0, ready}, 64'd0);
        check("clr_rdata", rdata[63:0], 64'd0);
        wait_ready(20, n);
        check("clr_len", 64'(n), 64'd32);
        read_all(acc);
        check("clr_all_zero", acc, 64'd0);

        // rst in the middle of a clear restarts the count
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready(-1, n);
        check("rst_mid_clear_len", 64'(n), 64'd32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
